dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of n-bit storage words (power of two).
REQ-003 The block SHALL have parameter LAT, default 2, meaning wait cycles between request acceptance and the response (0..15).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1, meaning the initiator presents a load/store request.
REQ-007 The block SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1, where 1 = store and 0 = load.
REQ-009 The block SHALL have port req_funct3, input, 3, the RISC-V load/store funct3 field.
REQ-010 The block SHALL have port req_addr, input, n, the byte address.
REQ-011 The block SHALL have port req_wdata, input, n, the store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-013 The block SHALL have port rsp_ready, input, 1, meaning the initiator takes the response.
REQ-014 The block SHALL have port rsp_rdata, output, n, the load result, sign- or zero-extended.
REQ-015 The block SHALL have port rsp_err, output, 1, meaning a misaligned or illegal request.
REQ-016 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, WAIT and RESP, and SHALL hold req_ready=1 only in IDLE.
REQ-018 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; the block SHALL latch req_we, req_funct3, req_addr and req_wdata on that edge.
REQ-019 On acceptance the FSM SHALL move IDLE->WAIT with a down-counter loaded with LAT; if LAT=0 it SHALL move IDLE->RESP directly.
REQ-020 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move WAIT->RESP on the edge where the counter equals 1.
REQ-021 The first rsp_valid SHALL therefore occur LAT+1 cycles after the acceptance edge.
REQ-022 In RESP the block SHALL hold rsp_valid=1 and keep rsp_rdata and rsp_err stable until rsp_ready=1, then move RESP->IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle the response completes.
REQ-024 The storage word index SHALL be addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so address DEPTH*4 aliases address 0.
REQ-025 A request SHALL be flagged as an error when any of the following holds: halfword access with addr[0]=1; word access with addr[1:0]!=0; store with funct3>2; load with funct3 in {3,6,7}.
REQ-026 Loads SHALL decode funct3 as 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, selecting the byte lane addr[1:0] and the halfword lane addr[1].
REQ-027 lb and lh SHALL sign-extend to n bits, and lbu and lhu SHALL zero-extend.
REQ-028 Stores SHALL decode funct3 as 000 sb, writing req_wdata[7:0] to lane addr[1:0]; 001 sh, writing req_wdata[15:0] to lane addr[1]; and 010 sw, writing the full word.
REQ-029 Stores SHALL leave unaddressed bytes of the word unchanged.
REQ-030 A store SHALL be committed to storage only on the edge entering RESP and SHALL be committed exactly once.
REQ-031 An erroneous request SHALL NOT modify storage and SHALL return rsp_err=1 with rsp_rdata=0.
REQ-032 Store responses SHALL return rsp_rdata=0.
REQ-033 Load data SHALL reflect storage contents at the RESP entry edge.
REQ-034 In IDLE the block SHALL hold rsp_valid=0 and rsp_err=0.
REQ-035 req_valid while busy SHALL be ignored with no side effect.

Reset
REQ-036 While reset=1 the block SHALL force, on the next edge: state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, busy 0 and req_ready 1.
REQ-037 Reset asserted in WAIT SHALL abort the transaction, and a pending store SHALL NOT be committed.
REQ-038 Reset asserted in RESP SHALL drop the response.
REQ-039 Storage contents SHALL NOT be cleared by reset.
REQ-040 Requests presented while reset=1 SHALL NOT be accepted.

Verification
REQ-041 The bench SHALL cover a word round trip: sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_rdata=0xDEADBEEF and rsp_err=0, with rsp_valid exactly 3 cycles after each acceptance (LAT=2).
REQ-042 The bench SHALL cover byte extension: sw 0 to 0x4, then sb 0x80 to 0x5; lb 0x5 -> 0xFFFFFF80, lbu 0x5 -> 0x00000080, and lw 0x4 -> 0x00008000.
REQ-043 The bench SHALL cover misalignment and illegal funct3: lw 0x2 -> rsp_err=1 and rsp_rdata=0; sh 0x3 -> rsp_err=1 and a subsequent lw 0x0 shows storage unchanged; load funct3=011 -> rsp_err=1.
REQ-044 The bench SHALL cover backpressure: rsp_ready held 0 for 5 cycles on lw -> rsp_valid and rsp_rdata stable throughout and req_ready=0; the FSM reaches IDLE one cycle after rsp_ready=1.
REQ-045 The bench SHALL cover reset mid-operation: sw 0x12345678 to 0x8 with reset pulsed in WAIT -> no response; a later lw 0x8 returns the prior value.
REQ-046 The bench SHALL cover aliasing: with DEPTH=256, sw 0xA5A5A5A5 to 0x400, then lw 0x0 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Purpose:
//   Latency-configurable data-memory responder for a RISC-V style load/store
//   initiator. It accepts one request at a time, waits LAT cycles and then
//   presents a response. The response is held until the initiator takes it.
//   Byte, halfword and word loads/stores are supported with RISC-V funct3
//   encodings. Misaligned or illegal requests return rsp_err and have no
//   effect on storage.
//
// Parameters:
//   n      data and address width in bits
//   DEPTH  number of n-bit storage words (power of two)
//   LAT    wait cycles between acceptance and response (0..15)
//
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous active-high reset (storage is not cleared)
//   req_valid   initiator presents a request
//   req_ready   responder accepts a request (high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V load/store funct3
//   req_addr    byte address (bits above the word index are ignored)
//   req_wdata   right-aligned store data
//   rsp_valid   response presented
//   rsp_ready   initiator takes the response
//   rsp_rdata   extended load result (0 for stores and errors)
//   rsp_err     misaligned or illegal request
//   busy        FSM is not in IDLE

module dmem_responder #(
    parameter int n     = 32,
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]   cnt;
    logic         lat_we;
    logic [2:0]   lat_f3;
    logic [n-1:0] lat_addr;
    logic [n-1:0] lat_wdata;

    logic [n-1:0] mem [DEPTH];

    logic         accept;
    logic         enter_resp;
    logic         leave_resp;

    logic         cur_we;
    logic [2:0]   cur_f3;
    logic [n-1:0] cur_addr;
    logic [n-1:0] cur_wdata;
    logic [AW-1:0] idx;
    logic         cur_err;
    logic [n-1:0] rd_word;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    logic [n-1:0] ld_data;
    logic [n-1:0] wr_word;

    logic [n-1:0] rdata_q;
    logic         err_q;

    logic         unused_addr_bits;

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State register; reset overrides any transition, which also aborts a
    // transaction in WAIT or RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. enter_resp marks the edge on which the transaction is
    // resolved: storage is read/written and the response registers load.
    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        leave_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LAT == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    leave_resp = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With LAT=0 the transaction resolves on the acceptance edge itself, before
    // the latched copy exists, so the live request fields are used in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_f3    = req_funct3;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = lat_we;
            cur_f3    = lat_f3;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign idx              = cur_addr[AW+1:2];
    assign unused_addr_bits = ^{cur_addr[n-1:AW+2]};

    // Error decode: misaligned halfword/word and funct3 codes with no meaning
    // for the access direction.
    always_comb begin
        cur_err = 1'b0;
        if (cur_we) begin
            if (cur_f3 > 3'd2) begin
                cur_err = 1'b1;
            end
        end else begin
            if (cur_f3 == 3'd3 || cur_f3 == 3'd6 || cur_f3 == 3'd7) begin
                cur_err = 1'b1;
            end
        end
        if (cur_f3[1:0] == 2'b01 && cur_addr[0]) begin
            cur_err = 1'b1;
        end
        if (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) begin
            cur_err = 1'b1;
        end
    end

    // Load lane selection and extension.
    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        rd_half = rd_word[{cur_addr[1], 4'b0000} +: 16];
        case (cur_f3)
            3'b000:  ld_data = {{(n-8){rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{(n-16){rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {{(n-8){1'b0}}, rd_byte};
            3'b101:  ld_data = {{(n-16){1'b0}}, rd_half};
            default: ld_data = '0;
        endcase
    end

    // Store merge: only the addressed lane changes, the rest of the word is
    // carried over from the current contents.
    always_comb begin
        wr_word = rd_word;
        case (cur_f3[1:0])
            2'b00:   wr_word[{cur_addr[1:0], 3'b000} +: 8]  = cur_wdata[7:0];
            2'b01:   wr_word[{cur_addr[1], 4'b0000} +: 16]  = cur_wdata[15:0];
            2'b10:   wr_word = cur_wdata;
            default: wr_word = rd_word;
        endcase
    end

    // Request latch, wait counter and response registers. The response
    // registers are cleared on the way back to IDLE so rsp_err reads 0 there.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= 4'(LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= cur_err;
                rdata_q <= (cur_err || cur_we) ? '0 : ld_data;
            end else if (leave_resp) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Storage has no reset. A store commits only on the single edge that
    // enters RESP, so it can never be written twice or after an abort.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && cur_we && !cur_err) begin
            mem[idx] <= wr_word;
        end
    end

endmodule
